// File: rtl/ac_store_drain.sv
// Store drain buffer: queues {addr,data} stores and writes them to memory in FIFO order (opt. AC_STORE_DRAIN_BYPASS_EN).
// Latency: head is presented the cycle after its push (same cycle via bypass); each pop takes one mem_ack.
// Backpressure: mem_we holds the head stable until mem_ack; stores arriving while full are dropped and set sticky ovf.
module ac_store_drain #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             st_en,
   input  logic [WIDTH-1:0] st_addr,
   input  logic [WIDTH-1:0] st_data,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_din,
   input  logic             mem_ack
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [AW:0]      count_q;
   logic [AW-1:0]    rd_q;
   logic [AW-1:0]    wr_q;
   logic             ovf_q;
   logic [WIDTH-1:0] addr_mem [DEPTH];
   logic [WIDTH-1:0] data_mem [DEPTH];
   logic             push;
   logic             pop;
   logic             byp;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign ovf   = ovf_q;

`ifdef AC_STORE_DRAIN_BYPASS_EN
   // rst_b gate keeps mem_we low during reset even if st_en is asserted
   assign byp = empty & st_en & rst_b;
`else
   assign byp = 1'b0;
`endif

   assign pop  = ~empty & mem_ack;
   assign push = st_en & ~full & ~(byp & mem_ack);

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (!empty) begin
         mem_we   = 1'b1;
         mem_addr = addr_mem[rd_q];
         mem_din  = data_mem[rd_q];
      end else if (byp) begin
         mem_we   = 1'b1;
         mem_addr = st_addr;
         mem_din  = st_data;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
         if (st_en && full) ovf_q <= 1'b1;
      end
   end

   // Storage is deliberately unreset; entries are only visible while count is nonzero
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_q] <= st_addr;
         data_mem[wr_q] <= st_data;
      end
   end

endmodule

// File: doc/ac_store_drain.md
AC_STORE_DRAIN -- requirements
Module: ac_store_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: number of buffer entries; power of two, 2 or more.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_b, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port st_en, input, 1: store request from the datapath; value presented this cycle.
REQ-006 SHALL have port st_addr, input, WIDTH: target memory address of the store.
REQ-007 SHALL have port st_data, input, WIDTH: accumulator value to store.
REQ-008 SHALL have port full, output, 1: buffer holds DEPTH entries.
REQ-009 SHALL have port empty, output, 1: buffer holds zero entries.
REQ-010 SHALL have port ovf, output, 1: sticky flag; a store was dropped.
REQ-011 SHALL have port mem_we, output, 1: memory write request.
REQ-012 SHALL have port mem_addr, output, WIDTH: write address, valid while mem_we=1.
REQ-013 SHALL have port mem_din, output, WIDTH: write data, valid while mem_we=1.
REQ-014 SHALL have port mem_ack, input, 1: memory accepted the current write; one-cycle pulse.

Function
REQ-015 SHALL buffer stores as {addr,data} pairs in FIFO order, with a count of 0..DEPTH and wrapping read and write pointers of log2(DEPTH) bits.
REQ-016 SHALL push on a rising edge when st_en=1 and full=0; full is taken from the registered count before any same-cycle pop.
REQ-017 SHALL drop st_en when full=1, even if a pop occurs the same cycle; ovf SHALL then set on that edge and stay set until reset.
REQ-018 SHALL drive mem_we=1 while empty=0, with mem_addr/mem_din equal to the head entry, held stable until ack.
REQ-019 SHALL pop the head on an edge where mem_we=1 and mem_ack=1; mem_ack while mem_we=0 SHALL be ignored.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop when not full; both pointers advance.
REQ-021 SHALL drive mem_addr and mem_din to 0 whenever mem_we=0.
REQ-022 SHALL derive full and empty from the registered count, with no combinational path from st_en or mem_ack.
REQ-023 SHALL deliver the head entry at least one cycle after it is pushed when bypass is disabled; per-entry transfer latency is 1 cycle plus the memory ack delay.

Reset
REQ-024 SHALL, while rst_b=0, asynchronously force count=0, both pointers=0, ovf=0, empty=1, full=0, mem_we=0, mem_addr=0 and mem_din=0.
REQ-025 SHALL discard all buffered entries on a reset mid-operation; an ack pending at reset SHALL be lost without a pop after release.
REQ-026 SHALL leave buffer storage contents unreset; they are unobservable while empty=1.

Configuration
REQ-027 SHALL use macro AC_STORE_DRAIN_BYPASS_EN to select the empty-buffer bypass.
REQ-028 SHALL, with AC_STORE_DRAIN_BYPASS_EN defined and empty=1 and st_en=1, drive mem_we=1, mem_addr=st_addr and mem_din=st_data combinationally in the same cycle.
REQ-029 SHALL, in that bypass case with mem_ack=1, complete the store without a push; with mem_ack=0 it SHALL push normally.
REQ-030 SHALL, with AC_STORE_DRAIN_BYPASS_EN undefined, never drive mem_we combinationally from st_en.

Verification
REQ-031 SHALL cover in-order drain: push (0x0010,0x1234) then (0x0011,0xABCD), mem_ack held 1 -> mem_we high 2 cycles, writes 0x1234@0x0010 then 0xABCD@0x0011, then empty=1.
REQ-032 SHALL cover full and overflow: 5 pushes, mem_ack=0 -> full=1 after the 4th, 5th dropped, ovf=1; 4 acks -> 4 writes in order, ovf still 1.
REQ-033 SHALL cover push while full with a same-cycle ack: count stays 3 after the edge, the store is dropped, and ovf=1.
REQ-034 SHALL cover a held-off ack: 1 entry, mem_ack=0 for 5 cycles -> mem_we, mem_addr and mem_din stable for all 5 cycles, pop on the first ack.
REQ-035 SHALL cover bypass: empty buffer, st_en with data 0x00FF, mem_ack=1 the same cycle -> mem_din=0x00FF that cycle and empty stays 1 with the macro; with the macro undefined, the write appears the next cycle.
REQ-036 SHALL cover reset mid-operation: 3 entries, rst_b pulsed low -> empty=1, mem_we=0 and ovf=0 immediately, and no writes after release.
